// File: rtl/turn_sequencer.sv
// turn_sequencer: game-flow controller for the 3x3 board datapath.
// Alternates player/computer turns, validates requested cells against the
// current board, strobes single-cycle writes into the position registers,
// latches the game result and forfeits a computer that fails to respond.
module turn_sequencer #(
  parameter int FIRST_MOVER = 0,
  parameter int PC_TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pl_valid,
  input  logic [3:0]  pl_pos,
  output logic        pl_ready,
  input  logic        pc_valid,
  input  logic [3:0]  pc_pos,
  output logic        pc_ready,
  input  logic [17:0] board,
  input  logic        win,
  input  logic [1:0]  who,
  input  logic        no_space,
  output logic        board_clr,
  output logic        wr_en,
  output logic [3:0]  wr_idx,
  output logic [1:0]  wr_mark,
  output logic [1:0]  turn,
  output logic        illegal,
  output logic        timeout,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [3:0]  move_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_WAIT_PL = 3'd2;
  localparam logic [2:0] S_WAIT_PC = 3'd3;
  localparam logic [2:0] S_COMMIT  = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [2:0]  FIRST_WAIT  = (FIRST_MOVER == 0) ? S_WAIT_PL : S_WAIT_PC;
  localparam logic [15:0] TIMEOUT_LIM = 16'(PC_TIMEOUT);

  localparam logic [1:0] MARK_PL   = 2'b01;
  localparam logic [1:0] MARK_PC   = 2'b10;
  localparam logic [1:0] MARK_DRAW = 2'b11;

  // True when pos names a real cell that is currently empty; any index
  // beyond 8 falls to the default and is reported as occupied.
  function automatic logic cell_free(input logic [17:0] b, input logic [3:0] pos);
    logic [1:0] c;
    case (pos)
      4'd0:    c = b[1:0];
      4'd1:    c = b[3:2];
      4'd2:    c = b[5:4];
      4'd3:    c = b[7:6];
      4'd4:    c = b[9:8];
      4'd5:    c = b[11:10];
      4'd6:    c = b[13:12];
      4'd7:    c = b[15:14];
      4'd8:    c = b[17:16];
      default: c = 2'b11;
    endcase
    return (c == 2'b00);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  wr_idx_q, wr_idx_d;
  logic [1:0]  wr_mark_q, wr_mark_d;
  logic [1:0]  winner_q, winner_d;
  logic [3:0]  move_count_q, move_count_d;
  logic [1:0]  turn_q, turn_d;
  logic        pl_ready_q, pl_ready_d;
  logic        pc_ready_q, pc_ready_d;
  logic        board_clr_q, board_clr_d;
  logic        wr_en_q, wr_en_d;
  logic        timeout_q, timeout_d;
  logic        game_over_q, game_over_d;
  logic        illegal_c;

  // Next-state, captured move, result and forfeit-counter decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_idx_d     = wr_idx_q;
    wr_mark_d    = wr_mark_q;
    winner_d     = winner_q;
    move_count_d = move_count_q;
    illegal_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_CLEAR;
          move_count_d = 4'd0;
          winner_d     = 2'b00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = FIRST_WAIT;
        cnt_d   = 16'd0;
      end
      S_WAIT_PL: begin
        if (pl_valid) begin
          if (cell_free(board, pl_pos)) begin
            wr_idx_d  = pl_pos;
            wr_mark_d = MARK_PL;
            state_d   = S_COMMIT;
          end else begin
            illegal_c = 1'b1;
          end
        end else begin
          state_d = S_WAIT_PL;
        end
      end
      S_WAIT_PC: begin
        // The forfeit check wins over any request arriving in the same cycle.
        if (cnt_q == TIMEOUT_LIM) begin
          state_d  = S_DONE;
          winner_d = MARK_PL;
        end else if (pc_valid) begin
          if (cell_free(board, pc_pos)) begin
            wr_idx_d  = pc_pos;
            wr_mark_d = MARK_PC;
            state_d   = S_COMMIT;
          end else begin
            illegal_c = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_COMMIT: begin
        move_count_d = move_count_q + 4'd1;
        state_d      = S_CHECK;
      end
      S_CHECK: begin
        cnt_d = 16'd0;
        if (win) begin
          winner_d = who;
          state_d  = S_DONE;
        end else if (no_space) begin
          winner_d = MARK_DRAW;
          state_d  = S_DONE;
        end else if (turn_q == MARK_PL) begin
          state_d = S_WAIT_PC;
        end else begin
          state_d = S_WAIT_PL;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flops are loaded from the upcoming state so they line up with it.
  always_comb begin
    pl_ready_d  = (state_d == S_WAIT_PL);
    timeout_d   = (state_d == S_WAIT_PC) && (cnt_d == TIMEOUT_LIM);
    pc_ready_d  = (state_d == S_WAIT_PC) && !timeout_d;
    board_clr_d = (state_d == S_CLEAR);
    wr_en_d     = (state_d == S_COMMIT);
    game_over_d = (state_d == S_DONE);
    case (state_d)
      S_WAIT_PL: turn_d = MARK_PL;
      S_WAIT_PC: turn_d = MARK_PC;
      S_COMMIT:  turn_d = turn_q;
      S_CHECK:   turn_d = turn_q;
      default:   turn_d = 2'b00;
    endcase
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      wr_idx_q     <= 4'd0;
      wr_mark_q    <= 2'b00;
      winner_q     <= 2'b00;
      move_count_q <= 4'd0;
      turn_q       <= 2'b00;
      pl_ready_q   <= 1'b0;
      pc_ready_q   <= 1'b0;
      board_clr_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      timeout_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_idx_q     <= wr_idx_d;
      wr_mark_q    <= wr_mark_d;
      winner_q     <= winner_d;
      move_count_q <= move_count_d;
      turn_q       <= turn_d;
      pl_ready_q   <= pl_ready_d;
      pc_ready_q   <= pc_ready_d;
      board_clr_q  <= board_clr_d;
      wr_en_q      <= wr_en_d;
      timeout_q    <= timeout_d;
      game_over_q  <= game_over_d;
    end
  end

  // The rejection pulse must coincide with the offending handshake cycle.
  assign illegal    = illegal_c;
  assign pl_ready   = pl_ready_q;
  assign pc_ready   = pc_ready_q;
  assign board_clr  = board_clr_q;
  assign wr_en      = wr_en_q;
  assign wr_idx     = wr_idx_q;
  assign wr_mark    = wr_mark_q;
  assign turn       = turn_q;
  assign timeout    = timeout_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign move_count = move_count_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with a behavioural board, winner detector
// and no-space detector around it.
module tb_turn_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        pl_valid;
  logic [3:0]  pl_pos;
  logic        pl_ready;
  logic        pc_valid;
  logic [3:0]  pc_pos;
  logic        pc_ready;
  logic [17:0] board;
  logic        win;
  logic [1:0]  who;
  logic        no_space;
  logic        board_clr;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [1:0]  wr_mark;
  logic [1:0]  turn;
  logic        illegal;
  logic        timeout;
  logic        game_over;
  logic [1:0]  winner;
  logic [3:0]  move_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  int bad = 0;

  localparam int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  turn_sequencer #(.FIRST_MOVER(0), .PC_TIMEOUT(10)) dut (
    .clock(clock), .reset(reset), .start(start),
    .pl_valid(pl_valid), .pl_pos(pl_pos), .pl_ready(pl_ready),
    .pc_valid(pc_valid), .pc_pos(pc_pos), .pc_ready(pc_ready),
    .board(board), .win(win), .who(who), .no_space(no_space),
    .board_clr(board_clr), .wr_en(wr_en), .wr_idx(wr_idx), .wr_mark(wr_mark),
    .turn(turn), .illegal(illegal), .timeout(timeout), .game_over(game_over),
    .winner(winner), .move_count(move_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Position registers: cleared by reset or board_clr, written by wr_en.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) board <= 18'd0;
    else if (board_clr) board <= 18'd0;
    else if (wr_en && wr_idx <= 4'd8) board[2*int'(wr_idx) +: 2] <= wr_mark;
  end

  // Winner and no-space detectors, combinational on the board.
  always_comb begin
    logic [1:0] c0, c1, c2;
    win = 1'b0;
    who = 2'b00;
    no_space = 1'b1;
    for (int l = 0; l < 8; l++) begin
      c0 = board[2*LN[l][0] +: 2];
      c1 = board[2*LN[l][1] +: 2];
      c2 = board[2*LN[l][2] +: 2];
      if (c0 != 2'b00 && c0 == c1 && c1 == c2) begin
        win = 1'b1;
        who = c0;
      end
    end
    for (int i = 0; i < 9; i++) begin
      if (board[2*i +: 2] == 2'b00) no_space = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one legal move from the side on turn and follow it through
  // COMMIT and CHECK, ending at the negedge after the decision.
  task automatic move(input logic side_pc, input logic [3:0] pos, input logic last);
    chk("ready_before_move", side_pc ? pc_ready : pl_ready, 32'd1);
    if (side_pc) begin
      pc_valid = 1'b1; pc_pos = pos;
    end else begin
      pl_valid = 1'b1; pl_pos = pos;
    end
    #1 chk("illegal_on_legal", illegal, 32'd0);
    @(negedge clock);
    pl_valid = 1'b0;
    pc_valid = 1'b0;
    chk("commit_wr_en", wr_en, 32'd1);
    chk("commit_wr_idx", wr_idx, pos);
    chk("commit_wr_mark", wr_mark, side_pc ? 32'd2 : 32'd1);
    exp_count++;
    @(negedge clock);
    chk("check_wr_en_low", wr_en, 32'd0);
    chk("check_move_count", move_count, exp_count);
    @(negedge clock);
    chk("turn_after_move", turn, last ? 32'd0 : (side_pc ? 32'd1 : 32'd2));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    pl_valid = 1'b0; pl_pos = 4'd0; pc_valid = 1'b0; pc_pos = 4'd0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {turn, game_over, winner, move_count, pl_ready, pc_ready,
                          wr_en, board_clr, illegal, timeout, wr_idx, wr_mark}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_turn", turn, 32'd0);

    // Game 1: start, player 4, off-turn request, illegal computer requests
    start = 1'b1;
    @(negedge clock);
    chk("clear_pulse", board_clr, 32'd1);
    chk("clear_turn", turn, 32'd0);
    start = 1'b0;
    @(negedge clock);
    chk("clear_one_cycle", board_clr, 32'd0);
    chk("first_turn", turn, 32'd1);
    chk("first_pc_ready", pc_ready, 32'd0);
    move(1'b0, 4'd4, 1'b0);
    chk("pc_turn_pl_ready", pl_ready, 32'd0);

    pl_valid = 1'b1; pl_pos = 4'd0;
    #1 chk("offturn_illegal", illegal, 32'd0);
    @(negedge clock);
    chk("offturn_no_write", wr_en, 32'd0);
    chk("offturn_pl_ready", pl_ready, 32'd0);
    pl_valid = 1'b0;

    pc_valid = 1'b1; pc_pos = 4'd4;
    #1 chk("pc_occupied_illegal", illegal, 32'd1);
    @(negedge clock);
    chk("pc_occupied_no_write", wr_en, 32'd0);
    chk("pc_occupied_turn", turn, 32'd2);
    pc_pos = 4'd9;
    #1 chk("pc_range_illegal", illegal, 32'd1);
    @(negedge clock);
    chk("pc_range_no_write", wr_en, 32'd0);
    chk("pc_range_turn", turn, 32'd2);
    pc_valid = 1'b0;
    move(1'b1, 4'd5, 1'b0);

    // start is ignored mid-game
    start = 1'b1;
    @(negedge clock);
    chk("start_ignored_clr", board_clr, 32'd0);
    chk("start_ignored_ready", pl_ready, 32'd1);
    start = 1'b0;

    // Reset in the middle of COMMIT
    pl_valid = 1'b1; pl_pos = 4'd0;
    @(negedge clock);
    pl_valid = 1'b0;
    chk("pre_reset_commit", wr_en, 32'd1);
    reset = 1'b1;
    #1 chk("async_reset_outputs", {turn, game_over, winner, move_count, pl_ready, pc_ready,
                                   wr_en, board_clr, illegal, timeout}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_count = 0;

    // Game 2: player wins on the top row
    start = 1'b1;
    @(negedge clock);
    chk("g2_clear", board_clr, 32'd1);
    start = 1'b0;
    @(negedge clock);
    move(1'b0, 4'd0, 1'b0);
    move(1'b1, 4'd3, 1'b0);
    move(1'b0, 4'd1, 1'b0);
    move(1'b1, 4'd4, 1'b0);
    move(1'b0, 4'd2, 1'b1);
    chk("g2_game_over", game_over, 32'd1);
    chk("g2_winner", winner, 32'd1);
    chk("g2_move_count", move_count, 32'd5);
    chk("g2_readies", {pl_ready, pc_ready}, 32'd0);
    pl_valid = 1'b1; pl_pos = 4'd5; pc_valid = 1'b1; pc_pos = 4'd6;
    #1 chk("done_no_illegal", illegal, 32'd0);
    @(negedge clock);
    chk("done_no_write", wr_en, 32'd0);
    chk("done_readies", {pl_ready, pc_ready}, 32'd0);
    chk("done_winner_held", winner, 32'd1);
    pl_valid = 1'b0; pc_valid = 1'b0;

    // DONE -> IDLE -> CLEAR with start held
    start = 1'b1;
    @(negedge clock);
    chk("idle_game_over_low", game_over, 32'd0);
    @(negedge clock);
    chk("g3_clear", board_clr, 32'd1);
    chk("g3_winner_cleared", winner, 32'd0);
    chk("g3_count_cleared", move_count, 32'd0);
    start = 1'b0;
    exp_count = 0;
    @(negedge clock);

    // Game 3: computer forfeits
    move(1'b0, 4'd0, 1'b0);
    bad = 0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clock);
      if (timeout || wr_en || illegal) bad++;
    end
    chk("no_early_timeout", bad, 32'd0);
    @(negedge clock);
    chk("timeout_pulse", timeout, 32'd1);
    chk("timeout_pc_ready", pc_ready, 32'd0);
    chk("timeout_no_write", wr_en, 32'd0);
    @(negedge clock);
    chk("timeout_one_cycle", timeout, 32'd0);
    chk("timeout_game_over", game_over, 32'd1);
    chk("timeout_winner", winner, 32'd1);
    chk("timeout_count", move_count, 32'd1);

    // Game 4: nine moves, no line -> draw
    start = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("g4_clear", board_clr, 32'd1);
    start = 1'b0;
    exp_count = 0;
    @(negedge clock);
    move(1'b0, 4'd0, 1'b0);
    move(1'b1, 4'd1, 1'b0);
    move(1'b0, 4'd2, 1'b0);
    move(1'b1, 4'd4, 1'b0);
    move(1'b0, 4'd3, 1'b0);
    move(1'b1, 4'd5, 1'b0);
    move(1'b0, 4'd7, 1'b0);
    move(1'b1, 4'd6, 1'b0);
    move(1'b0, 4'd8, 1'b1);
    chk("draw_winner", winner, 32'd3);
    chk("draw_move_count", move_count, 32'd9);
    chk("draw_game_over", game_over, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-flow controller for the 3x3 board datapath: position registers, winner detector and no-space detector.
- Arbitrates move requests from the player and computer sources and enforces strict alternation.
- Validates each move against the current board and issues single-cycle write strobes to the board registers.
- Samples win/draw status after each commit and latches the game result; also handles computer-response timeout (forfeit) and board clear for a new game.

Parameters:
- FIRST_MOVER, 0, side that moves first after start (0 = player, 1 = computer).
- PC_TIMEOUT, 255, maximum cycles spent in WAIT_PC without a computer request before forfeit (1..65535).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  level; begins a game from IDLE, or returns to IDLE from DONE
- pl_valid  input  1  player move request
- pl_pos  input  4  player cell index (0..8)
- pl_ready  output  1  player request accepted this cycle when pl_valid & pl_ready
- pc_valid  input  1  computer move request
- pc_pos  input  4  computer cell index (0..8)
- pc_ready  output  1  computer handshake ready
- board  input  18  cell i at bits [2i+1:2i]; 00 empty, 01 player, 10 computer
- win  input  1  winner detector output (combinational on board)
- who  input  2  winning mark from detector
- no_space  input  1  all nine cells occupied
- board_clr  output  1  one-cycle synchronous clear of all position registers
- wr_en  output  1  one-cycle write strobe
- wr_idx  output  4  cell index to write
- wr_mark  output  2  mark to write (01 player, 10 computer)
- turn  output  2  01 = player to move, 10 = computer to move, 00 = no game in progress
- illegal  output  1  one-cycle pulse: rejected request
- timeout  output  1  one-cycle pulse: computer forfeit
- game_over  output  1  high while in DONE
- winner  output  2  01 player, 10 computer, 11 draw, 00 none
- move_count  output  4  legal moves committed this game (0..9)

Behaviour:
- Reset values: state = IDLE; all outputs 0; timeout counter = 0.
- States: IDLE, CLEAR, WAIT_PL, WAIT_PC, COMMIT, CHECK, DONE.
- IDLE: on start=1, go to CLEAR. turn=00.
- CLEAR: board_clr=1 for exactly one cycle; move_count and winner cleared. Next state is WAIT_PL if FIRST_MOVER=0, else WAIT_PC.
- WAIT_PL: pl_ready=1 and pc_ready=0.
  - Request is legal iff pl_pos <= 8 and board cell pl_pos == 00. Legality is evaluated combinationally in the handshake cycle.
  - Legal: capture wr_idx=pl_pos, wr_mark=01; go to COMMIT.
  - Illegal: illegal=1 for that cycle; stay in WAIT_PL. Board and turn unchanged.
- WAIT_PC: pc_ready=1 and pl_ready=0; legality rule is the same as WAIT_PL, with mark 10.
  - The 16-bit counter is cleared on entry and increments each cycle without pc_valid.
  - When counter == PC_TIMEOUT: timeout=1, winner=01, go to DONE. No write.
  - An illegal computer request pulses illegal and does not reset the counter.
- Requests from the side not on turn are ignored: ready stays low, no illegal pulse. Simultaneous pl_valid and pc_valid: only the side on turn is considered.
- COMMIT: wr_en=1 for one cycle with the captured wr_idx/wr_mark; move_count increments.
- CHECK: the board reflects the write, so win/no_space are valid.
  - win=1: winner=who, go to DONE.
  - Else no_space=1: winner=11, go to DONE.
  - Else go to the opposite WAIT state.
- Latency: accepting handshake edge -> wr_en the next cycle -> result or next-turn ready two cycles after acceptance.
- DONE: game_over=1, turn=00, winner held. Both ready signals are low. start=1 returns to IDLE.
- start is ignored in all states other than IDLE and DONE.
- turn tracks the WAIT state and holds its value through COMMIT/CHECK.
- wr_en, board_clr, illegal and timeout are never high in the same cycle.
- Asynchronous reset mid-game returns to IDLE immediately. Board contents are cleared by the registers' own reset.

Test Plan:
- Reset, then start with FIRST_MOVER=0 -> board_clr one cycle, turn=01, pl_ready=1; player pos 4 -> wr_en with wr_idx=4, wr_mark=01 one cycle later; turn=10 after CHECK; move_count=1.
- Player 0, computer 3, player 1, computer 4, player 2 -> win at CHECK after 5th commit, winner=01, game_over=1, move_count=5, no further ready.
- Computer requests pos 4 when board cell 4 = 01, then pos 9 -> illegal pulses twice; no wr_en; turn stays 10; then pos 5 accepted.
- WAIT_PC with pc_valid held 0, PC_TIMEOUT=10 -> timeout pulse 10 cycles after entry, winner=01, game_over=1, wr_en never asserted.
- Full nine-move game with no line -> winner=11, move_count=9.
- Reset asserted mid-COMMIT -> outputs 0 asynchronously.
- pl_valid asserted during the computer turn -> pl_ready=0, no illegal pulse.
